usb_protocol_ctrl: RTL
======================

USB_PROTOCOL_CTRL -- requirements
Module: usb_protocol_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255: clocks allowed, after this block's DATA packet ends, for the host handshake to arrive.
REQ-002 Parameter MAX_PACKET, 64: maximum buffer_occupancy in bytes for a valid data phase.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rx_packet  in  4  PID of the last received packet, from the receive block.
REQ-006 rx_data_ready  in  1  received data packet complete.
REQ-007 rx_transfer_active  in  1  receive block busy with a packet.
REQ-008 rx_error  in  1  receive block reported a bad packet.
REQ-009 tx_transfer_active  in  1  transmit block busy.
REQ-010 tx_error  in  1  transmit block aborted.
REQ-011 buffer_occupancy  in  7  bytes in the shared data buffer.
REQ-012 host_ready  in  1  host side has staged IN data.
REQ-013 tx_packet  out  3  request to transmitter: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL.
REQ-014 d_mode  out  1  1 = transmitter owns the bus.
REQ-015 flush  out  1  one-cycle buffer clear pulse.
REQ-016 rx_done  out  1  one-cycle pulse: OUT data accepted.
REQ-017 tx_done  out  1  one-cycle pulse: IN data acknowledged.
REQ-018 err_irq  out  1  sticky protocol error; cleared only by rst.

Function
REQ-019 States: IDLE, RX_WAIT, SEND_ACK, SEND_NAK, SEND_STALL, SEND_DATA, TX_WAIT, HS_WAIT; the block SHALL implement exactly these.
REQ-020 Packet end SHALL be the registered falling edge of rx_transfer_active, seen one cycle after the fall.
REQ-021 IDLE -> RX_WAIT on rx_transfer_active=1.
REQ-022 RX_WAIT, at packet end, SHALL branch as follows:
- rx_error=1 and PID DATA0/DATA1 -> SEND_NAK.
- rx_error=1, other PID -> IDLE, err_irq set.
- DATA0/DATA1 with buffer_occupancy>MAX_PACKET -> SEND_STALL, err_irq set.
- DATA0/DATA1, otherwise -> SEND_ACK.
- IN, host_ready=1, occupancy 1..MAX_PACKET -> SEND_DATA.
- IN, otherwise -> SEND_NAK.
- any other PID -> IDLE, no output.
REQ-023 SEND_* states SHALL drive tx_packet for exactly one cycle, then go to TX_WAIT; tx_packet=0 in every other state.
REQ-024 SEND_DATA SHALL drive DATA0 when toggle=0 and DATA1 when toggle=1.
REQ-025 d_mode SHALL be 1 from SEND_* entry until TX_WAIT exits.
REQ-026 TX_WAIT SHALL wait for tx_transfer_active to rise and then fall.
REQ-027 TX_WAIT exit routing:
- After ACK: pulse rx_done and flush, then IDLE.
- After NAK or STALL: IDLE.
- After DATA: HS_WAIT.
REQ-028 tx_error=1 in TX_WAIT -> IDLE, err_irq set, flush pulsed.
REQ-029 HS_WAIT SHALL count clocks from 0.
- Packet end with rx_packet=ACK, rx_error=0: flip toggle, pulse tx_done and flush, then IDLE.
- Any other packet end, or count reaching TIMEOUT_CYCLES-1: IDLE, err_irq set, toggle kept, buffer kept for retry.
REQ-030 A packet-end and a timeout in the same cycle SHALL resolve in favour of the packet.
REQ-031 The counter SHALL be 8 bits wide, cleared on HS_WAIT entry, and SHALL not wrap.

Reset
REQ-032 rst=1 SHALL force IDLE, toggle=0, counter=0, err_irq=0, tx_packet=0, d_mode=0, and flush/rx_done/tx_done=0, asynchronously; rst mid-transfer abandons the transfer with no pulses.

Structure
REQ-033 A shared package usb_pkg SHALL hold the PID constants (OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110), the tx_packet encoding, and the state enum.
REQ-034 The handshake timeout SHALL be one flex_counter sub-module instance; FSM and edge detection stay in usb_protocol_ctrl.

Verification
REQ-035 DATA0 packet, rx_error=0, occupancy 3 -> tx_packet=3 one cycle, d_mode through TX, then rx_done=1 and flush=1 one cycle.
REQ-036 DATA0 packet with rx_error=1 -> tx_packet=4, no rx_done, err_irq=0.
REQ-037 IN token, host_ready=1, occupancy 8 -> tx_packet=1, then host ACK -> tx_done pulse; second IN -> tx_packet=2.
REQ-038 IN after DATA, no host ACK within 255 cycles -> err_irq=1; next IN resends tx_packet=1.
REQ-039 IN with host_ready=0 -> tx_packet=4; DATA0 with occupancy 65 -> tx_packet=5, err_irq=1.
REQ-040 rst asserted in TX_WAIT -> all outputs 0 immediately; following DATA0 handled normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB protocol definitions: token/handshake PIDs, transmitter request
// codes and the protocol controller state encoding.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5
    } tx_pkt_t;

    typedef enum logic [2:0] {
        IDLE,
        RX_WAIT,
        SEND_ACK,
        SEND_NAK,
        SEND_STALL,
        SEND_DATA,
        TX_WAIT,
        HS_WAIT
    } state_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that saturates at rollover_val instead of
// wrapping; rollover_flag is high while the count sits at that value.
module flex_counter #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count,
    output logic                rollover_flag
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable && (count != rollover_val)) begin
            count <= count + 1'b1;
        end
    end

    assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// USB device-side protocol controller: decodes received packets, requests
// handshakes/data from the transmitter and tracks the DATA0/DATA1 toggle.
module usb_protocol_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_PACKET     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_transfer_active,
    input  logic       rx_error,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic [6:0] buffer_occupancy,
    input  logic       host_ready,
    output logic [2:0] tx_packet,
    output logic       d_mode,
    output logic       flush,
    output logic       rx_done,
    output logic       tx_done,
    output logic       err_irq
);

    localparam logic [6:0] MAX_OCC      = 7'(MAX_PACKET);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t  state, next_state;
    tx_pkt_t sent_kind, sent_next;
    tx_pkt_t tx_req;
    logic    rx_active_d1, rx_active_d2;
    logic    packet_end;
    logic    toggle, toggle_next;
    logic    tx_seen, tx_seen_next;
    logic    err_next, flush_next, rx_done_next, tx_done_next;
    logic    d_mode_next;
    logic    hs_clear, hs_timeout;
    logic [7:0] hs_count;

    // rx_data_ready is redundant with the registered fall of rx_transfer_active
    logic    unused_ok;
    assign unused_ok = rx_data_ready ^ (|hs_count);

    // Two-stage history so packet end is seen one cycle after the fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_active_d1 <= 1'b0;
            rx_active_d2 <= 1'b0;
        end else begin
            rx_active_d1 <= rx_transfer_active;
            rx_active_d2 <= rx_active_d1;
        end
    end

    assign packet_end = rx_active_d2 & ~rx_active_d1;

    assign hs_clear = (state != HS_WAIT);

    flex_counter #(
        .NUM_BITS(8)
    ) u_hs_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (hs_clear),
        .count_enable (1'b1),
        .rollover_val (TIMEOUT_LAST),
        .count        (hs_count),
        .rollover_flag(hs_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sent_kind <= TX_NONE;
            toggle    <= 1'b0;
            tx_seen   <= 1'b0;
            err_irq   <= 1'b0;
            flush     <= 1'b0;
            rx_done   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= next_state;
            sent_kind <= sent_next;
            toggle    <= toggle_next;
            tx_seen   <= tx_seen_next;
            err_irq   <= err_next;
            flush     <= flush_next;
            rx_done   <= rx_done_next;
            tx_done   <= tx_done_next;
        end
    end

    always_comb begin
        next_state   = state;
        sent_next    = sent_kind;
        toggle_next  = toggle;
        tx_seen_next = tx_seen;
        err_next     = err_irq;
        flush_next   = 1'b0;
        rx_done_next = 1'b0;
        tx_done_next = 1'b0;
        tx_req       = TX_NONE;
        d_mode_next  = 1'b0;

        case (state)
            IDLE: begin
                tx_seen_next = 1'b0;
                if (rx_transfer_active) begin
                    next_state = RX_WAIT;
                end
            end

            RX_WAIT: begin
                if (packet_end) begin
                    if (rx_error) begin
                        if (is_data_pid(rx_packet)) begin
                            next_state = SEND_NAK;
                        end else begin
                            next_state = IDLE;
                            err_next   = 1'b1;
                        end
                    end else if (is_data_pid(rx_packet)) begin
                        if (buffer_occupancy > MAX_OCC) begin
                            next_state = SEND_STALL;
                            err_next   = 1'b1;
                        end else begin
                            next_state = SEND_ACK;
                        end
                    end else if (rx_packet == PID_IN) begin
                        if (host_ready && (buffer_occupancy != 7'd0) &&
                            (buffer_occupancy <= MAX_OCC)) begin
                            next_state = SEND_DATA;
                        end else begin
                            next_state = SEND_NAK;
                        end
                    end else begin
                        next_state = IDLE;
                    end
                end
            end

            SEND_ACK, SEND_NAK, SEND_STALL, SEND_DATA: begin
                d_mode_next  = 1'b1;
                tx_seen_next = 1'b0;
                next_state   = TX_WAIT;
                case (state)
                    SEND_ACK:   tx_req = TX_ACK;
                    SEND_NAK:   tx_req = TX_NAK;
                    SEND_STALL: tx_req = TX_STALL;
                    default:    tx_req = toggle ? TX_DATA1 : TX_DATA0;
                endcase
                sent_next = tx_req;
            end

            TX_WAIT: begin
                d_mode_next = 1'b1;
                if (tx_error) begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                    flush_next = 1'b1;
                end else if (tx_transfer_active) begin
                    tx_seen_next = 1'b1;
                end else if (tx_seen) begin
                    case (sent_kind)
                        TX_ACK: begin
                            next_state   = IDLE;
                            rx_done_next = 1'b1;
                            flush_next   = 1'b1;
                        end
                        TX_DATA0, TX_DATA1: next_state = HS_WAIT;
                        default:            next_state = IDLE;
                    endcase
                end
            end

            HS_WAIT: begin
                // A packet arriving on the timeout cycle still takes priority.
                if (packet_end) begin
                    next_state = IDLE;
                    if ((rx_packet == PID_ACK) && !rx_error) begin
                        toggle_next  = ~toggle;
                        tx_done_next = 1'b1;
                        flush_next   = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (hs_timeout) begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    assign tx_packet = tx_req;
    assign d_mode    = d_mode_next;

endmodule
